// File: rtl/cube_color_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : cube_color_sampler
// Brief  : Averages RGB over a square window of the pixel stream, once per
//          frame. Define CUBE_SAMPLER_IIR_EN for 1/4-weight frame smoothing.
// Rev    : 1.0  initial release
// ============================================================================
module cube_color_sampler #(
    parameter int WIN_LOG2 = 4,
    parameter int H_MAX    = 639,
    parameter int V_MAX    = 479
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iFrame_start,
    input  logic       iFrame_end,
    input  logic       iDVAL,
    input  logic [9:0] iX,
    input  logic [9:0] iY,
    input  logic [7:0] iR,
    input  logic [7:0] iG,
    input  logic [7:0] iB,
    input  logic [9:0] iCubeX,
    input  logic [9:0] iCubeY,
    output logic [7:0] oColor_R,
    output logic [7:0] oColor_G,
    output logic [7:0] oColor_B,
    output logic       oColor_valid,
    output logic       oWin_err
);
    localparam int                 c_SHIFT = 2 * WIN_LOG2;
    localparam int                 c_SUM_W = 8 + c_SHIFT;
    localparam int                 c_CNT_W = c_SHIFT + 1;
    localparam logic [10:0]        c_HALF  = 11'(2 ** (WIN_LOG2 - 1));
    localparam logic [10:0]        c_SPAN  = 11'(2 ** WIN_LOG2 - 1);
    localparam logic [10:0]        c_H_MAX = 11'(H_MAX);
    localparam logic [10:0]        c_V_MAX = 11'(V_MAX);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(2 ** c_SHIFT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [10:0]        r_x0, r_y0;
    logic               r_win_ok;
    logic [c_SUM_W-1:0] r_sum_r, r_sum_g, r_sum_b;
    logic [c_CNT_W-1:0] r_count;
    logic               r_pub_go, r_pub_err;
    logic [7:0]         r_avg_r, r_avg_g, r_avg_b;

    logic [10:0]        w_cube_x, w_cube_y, w_x0, w_y0, w_px, w_py;
    logic               w_win_ok, w_hit;
    logic [7:0]         w_next_r, w_next_g, w_next_b;

    // 11-bit arithmetic so a centre near the left/top edge wraps to a huge x0
    // instead of aliasing onto a legal coordinate.
    assign w_cube_x = {1'b0, iCubeX};
    assign w_cube_y = {1'b0, iCubeY};
    assign w_x0     = w_cube_x - c_HALF;
    assign w_y0     = w_cube_y - c_HALF;
    assign w_win_ok = (w_cube_x >= c_HALF) && (w_cube_y >= c_HALF) &&
                      (w_x0 + c_SPAN <= c_H_MAX) && (w_y0 + c_SPAN <= c_V_MAX);

    assign w_px  = {1'b0, iX};
    assign w_py  = {1'b0, iY};
    assign w_hit = iDVAL && (w_px >= r_x0) && (w_px <= r_x0 + c_SPAN) &&
                   (w_py >= r_y0) && (w_py <= r_y0 + c_SPAN);

`ifdef CUBE_SAMPLER_IIR_EN
    logic r_primed;

    function automatic logic [7:0] smooth(input logic [7:0] old, input logic [7:0] avg,
                                          input logic primed);
        logic signed [8:0] diff;
        logic signed [8:0] step;
        diff = $signed({1'b0, avg}) - $signed({1'b0, old});
        step = diff >>> 2;
        return primed ? old + step[7:0] : avg;
    endfunction

    assign w_next_r = smooth(oColor_R, r_avg_r, r_primed);
    assign w_next_g = smooth(oColor_G, r_avg_g, r_primed);
    assign w_next_b = smooth(oColor_B, r_avg_b, r_primed);
`else
    assign w_next_r = r_avg_r;
    assign w_next_g = r_avg_g;
    assign w_next_b = r_avg_b;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state      <= S_IDLE;
            r_x0         <= '0;
            r_y0         <= '0;
            r_win_ok     <= 1'b0;
            r_sum_r      <= '0;
            r_sum_g      <= '0;
            r_sum_b      <= '0;
            r_count      <= '0;
            r_pub_go     <= 1'b0;
            r_pub_err    <= 1'b0;
            r_avg_r      <= '0;
            r_avg_g      <= '0;
            r_avg_b      <= '0;
            oColor_R     <= 8'hFF;
            oColor_G     <= 8'hFF;
            oColor_B     <= 8'hFF;
            oColor_valid <= 1'b0;
            oWin_err     <= 1'b0;
`ifdef CUBE_SAMPLER_IIR_EN
            r_primed     <= 1'b0;
`endif
        end else begin
            r_pub_go     <= 1'b0;
            r_pub_err    <= 1'b0;
            oColor_valid <= 1'b0;

            // Output stage: one cycle behind the DONE decision.
            if (r_pub_go) begin
                oColor_R     <= w_next_r;
                oColor_G     <= w_next_g;
                oColor_B     <= w_next_b;
                oColor_valid <= 1'b1;
                oWin_err     <= 1'b0;
`ifdef CUBE_SAMPLER_IIR_EN
                r_primed     <= 1'b1;
`endif
            end else if (r_pub_err) begin
                oWin_err <= 1'b1;
            end

            if (r_state == S_DONE) begin
                if (r_win_ok && (r_count == c_FULL)) begin
                    r_pub_go <= 1'b1;
                    r_avg_r  <= 8'(r_sum_r >> c_SHIFT);
                    r_avg_g  <= 8'(r_sum_g >> c_SHIFT);
                    r_avg_b  <= 8'(r_sum_b >> c_SHIFT);
                end else begin
                    r_pub_err <= 1'b1;
                end
            end

            // A frame start in any state (re)opens accumulation.
            if (iFrame_start) begin
                r_state  <= S_ACCUM;
                r_x0     <= w_x0;
                r_y0     <= w_y0;
                r_win_ok <= w_win_ok;
                r_sum_r  <= '0;
                r_sum_g  <= '0;
                r_sum_b  <= '0;
                r_count  <= '0;
            end else begin
                case (r_state)
                    S_ACCUM: begin
                        if (w_hit) begin
                            r_sum_r <= r_sum_r + c_SUM_W'(iR);
                            r_sum_g <= r_sum_g + c_SUM_W'(iG);
                            r_sum_b <= r_sum_b + c_SUM_W'(iB);
                            // Saturate so a flood of duplicates never wraps back to "full".
                            if (r_count != '1)
                                r_count <= r_count + c_CNT_W'(1);
                        end
                        if (iFrame_end)
                            r_state <= S_DONE;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cube_color_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_cube_color_sampler
// Brief  : Randomised frames against a frame-level average model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cube_color_sampler;
    localparam int HALF  = 8;
    localparam int NPIX  = 256;
    localparam int H_MAX = 639;
    localparam int V_MAX = 479;

    logic       iCLK = 1'b0, iRST_N = 1'b0;
    logic       iFrame_start = 1'b0, iFrame_end = 1'b0, iDVAL = 1'b0;
    logic [9:0] iX = '0, iY = '0, iCubeX = '0, iCubeY = '0;
    logic [7:0] iR = '0, iG = '0, iB = '0;
    logic [7:0] oColor_R, oColor_G, oColor_B;
    logic       oColor_valid, oWin_err;

    cube_color_sampler dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iFrame_start(iFrame_start), .iFrame_end(iFrame_end),
        .iDVAL(iDVAL), .iX(iX), .iY(iY), .iR(iR), .iG(iG), .iB(iB),
        .iCubeX(iCubeX), .iCubeY(iCubeY), .oColor_R(oColor_R), .oColor_G(oColor_G),
        .oColor_B(oColor_B), .oColor_valid(oColor_valid), .oWin_err(oWin_err)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;

    typedef struct { bit v; bit pub; int r; int g; int b; } ev_t;
    ev_t ev_new, d1, d2;
    bit  m_active, m_primed;
    int  m_cx, m_cy, m_sr, m_sg, m_sb, m_cnt;
    int  exp_r, exp_g, exp_b;
    bit  exp_valid, exp_err;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int blend(input int old, input int avg);
`ifdef CUBE_SAMPLER_IIR_EN
        if (!m_primed) return avg;
        return old + ((avg - old) >>> 2);
`else
        return avg + 0 * old;
`endif
    endfunction

    task automatic model_reset();
        exp_r = 255; exp_g = 255; exp_b = 255;
        exp_valid = 0; exp_err = 0; m_active = 0; m_primed = 0;
        ev_new.v = 0; d1.v = 0; d2.v = 0;
    endtask

    // Published result appears two edges after the edge that samples iFrame_end.
    always @(posedge iCLK) begin
        #1;
        if (iRST_N) begin
            exp_valid = 0;
            if (d2.v) begin
                if (d2.pub) begin
                    exp_r = blend(exp_r, d2.r);
                    exp_g = blend(exp_g, d2.g);
                    exp_b = blend(exp_b, d2.b);
                    m_primed = 1; exp_valid = 1; exp_err = 0;
                end else begin
                    exp_err = 1;
                end
            end
            d2 = d1; d1 = ev_new; ev_new.v = 0;
            chk("valid", int'(oColor_valid), int'(exp_valid));
            chk("win_err", int'(oWin_err), int'(exp_err));
            chk("color_r", int'(oColor_R), exp_r);
            chk("color_g", int'(oColor_G), exp_g);
            chk("color_b", int'(oColor_B), exp_b);
        end
    end

    task automatic drive(input bit fs, input bit fe, input bit dv, input int x, input int y,
                         input int r, input int g, input int b, input int cx, input int cy);
        bit ok;
        @(negedge iCLK);
        iFrame_start = fs; iFrame_end = fe; iDVAL = dv;
        iX = 10'(x); iY = 10'(y); iR = 8'(r); iG = 8'(g); iB = 8'(b);
        iCubeX = 10'(cx); iCubeY = 10'(cy);
        if (fs) begin
            m_active = 1; m_cx = cx; m_cy = cy;
            m_sr = 0; m_sg = 0; m_sb = 0; m_cnt = 0;
        end else if (m_active) begin
            if (dv && x >= m_cx - HALF && x <= m_cx + HALF - 1 &&
                      y >= m_cy - HALF && y <= m_cy + HALF - 1) begin
                m_sr += r; m_sg += g; m_sb += b; m_cnt++;
            end
            if (fe) begin
                ok = (m_cx >= HALF) && (m_cy >= HALF) &&
                     (m_cx + HALF - 1 <= H_MAX) && (m_cy + HALF - 1 <= V_MAX);
                ev_new.v = 1; ev_new.pub = ok && (m_cnt == NPIX);
                ev_new.r = m_sr / NPIX; ev_new.g = m_sg / NPIX; ev_new.b = m_sb / NPIX;
                m_active = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 0, $urandom_range(0, H_MAX), $urandom_range(0, V_MAX),
                  $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
    endtask

    // kind: 0 uniform, 1 R checkerboard 00/FF, 2 random. defect: 1 duplicate, 2 hole.
    task automatic frame(input int cx, input int cy, input int kind, input int r0, input int g0,
                         input int b0, input int defect, input bit abort);
        int xs, xe, ys, ye, r, g, b;
        bit inw, last;
        drive(1, 0, 0, 0, 0, 0, 0, 0, cx, cy);
        if (abort) begin
            for (int i = 0; i < 30; i++)
                drive(0, 0, 1, cx - HALF + i % 16, cy - HALF + i / 16, $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 255), cx, cy);
            drive(1, 0, 0, 0, 0, 0, 0, 0, cx, cy);
        end
        xs = (cx - 10 < 0) ? 0 : cx - 10;
        ys = (cy - 10 < 0) ? 0 : cy - 10;
        xe = (cx + 7 > H_MAX) ? H_MAX : cx + 7;
        ye = (cy + 7 > V_MAX) ? V_MAX : cy + 7;
        for (int y = ys; y <= ye; y++) begin
            for (int x = xs; x <= xe; x++) begin
                if (defect == 2 && x == cx && y == cy) continue;
                if ($urandom_range(0, 3) == 0)
                    drive(0, 0, 0, cx, cy, $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), cx, cy);
                inw  = (x >= cx - HALF) && (y >= cy - HALF);
                last = (x == xe) && (y == ye);
                r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
                if (inw && kind == 0) begin r = r0; g = g0; b = b0; end
                if (inw && kind == 1) begin r = ((x + y) % 2 == 1) ? 255 : 0; g = g0; b = b0; end
                drive(0, last, 1, x, y, r, g, b, cx, cy);
                if (defect == 1 && x == cx && y == cy)
                    drive(0, 0, 1, x, y, r, g, b, cx, cy);
            end
        end
    endtask

    task automatic chk_color(input string name, input int r, input int g, input int b, input int e);
        @(negedge iCLK);
        chk({name, "_r"}, int'(oColor_R), r);
        chk({name, "_g"}, int'(oColor_G), g);
        chk({name, "_b"}, int'(oColor_B), b);
        chk({name, "_err"}, int'(oWin_err), e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge iCLK);
        chk_color("reset", 255, 255, 255, 0);
        chk("reset_valid", int'(oColor_valid), 0);
        iRST_N = 1'b1;
        idle(3);

        frame(320, 240, 0, 'h40, 'h80, 'hC0, 0, 0); idle(4);
        chk_color("uniform", 'h40, 'h80, 'hC0, 0);
        frame(5, 240, 0, 'h11, 'h22, 'h33, 0, 0); idle(4);
        chk_color("offscreen", 'h40, 'h80, 'hC0, 1);
`ifndef CUBE_SAMPLER_IIR_EN
        frame(320, 240, 1, 0, 'h55, 'h66, 0, 0); idle(4);
        chk_color("checker", 'h7F, 'h55, 'h66, 0);
        frame(200, 100, 0, 'h10, 'h10, 'h10, 0, 1); idle(4);
        chk_color("restart", 'h10, 'h10, 'h10, 0);
`endif

        // Asynchronous reset in the middle of an accumulating frame.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 320, 240);
        for (int i = 0; i < 10; i++) drive(0, 0, 1, 312 + i, 232, 9, 9, 9, 320, 240);
        @(negedge iCLK); #2;
        iRST_N = 1'b0; model_reset();
        #1;
        chk("midrst_r", int'(oColor_R), 255);
        chk("midrst_valid", int'(oColor_valid), 0);
        chk("midrst_err", int'(oWin_err), 0);
        @(negedge iCLK); iRST_N = 1'b1;
        idle(2);

`ifdef CUBE_SAMPLER_IIR_EN
        frame(320, 240, 0, 0, 0, 0, 0, 0); idle(4);
        chk_color("iir0", 0, 0, 0, 0);
        frame(320, 240, 0, 'h80, 'h80, 'h80, 0, 0); idle(4);
        chk_color("iir1", 'h20, 'h20, 'h20, 0);
        frame(320, 240, 0, 'h80, 'h80, 'h80, 0, 0); idle(4);
        chk_color("iir2", 'h38, 'h38, 'h38, 0);
        frame(320, 240, 0, 'h80, 'h80, 'h80, 0, 0); idle(4);
        chk_color("iir3", 'h4A, 'h4A, 'h4A, 0);
`endif

        // Window boundaries, defects, back-to-back frames, stray frame end.
        frame(8, 8, 2, 0, 0, 0, 0, 0);         idle(3);
        frame(632, 472, 2, 0, 0, 0, 0, 0);     idle(0);
        frame(633, 240, 2, 0, 0, 0, 0, 0);     idle(0);
        frame(320, 473, 2, 0, 0, 0, 0, 0);     idle(2);
        frame(320, 7, 2, 0, 0, 0, 0, 0);       idle(2);
        frame(100, 100, 2, 0, 0, 0, 0, 0);     idle(2);
        frame(300, 300, 2, 0, 0, 0, 1, 0);     idle(2);
        frame(400, 200, 2, 0, 0, 0, 2, 0);     idle(2);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);   idle(4);

        for (int n = 0; n < 10; n++) begin
            frame(($urandom_range(0, 4) == 0) ? $urandom_range(0, 660) : $urandom_range(8, 632),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, 500) : $urandom_range(8, 472),
                  $urandom_range(0, 2), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), ($urandom_range(0, 5) < 4) ? 0 : $urandom_range(1, 2),
                  $urandom_range(0, 4) == 0);
            idle($urandom_range(0, 3));
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
